// File: rtl/text_cursor_writer.sv
// Turns a byte stream into single-cell text-buffer writes, tracking the cursor and handling
// CR/LF/BS/FF. Clears the whole screen after reset or FF, and each new line as it is entered.
module text_cursor_writer #(
  parameter int unsigned ROW_NUMBER     = 15,
  parameter int unsigned COL_NUMBER     = 40,
  parameter int unsigned CHAR_ID_LENGTH = 8,
  parameter int unsigned ROW_BIT_LEN    = 4,
  parameter int unsigned COL_BIT_LEN    = 6,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      wr_en,
  output logic [ROW_BIT_LEN-1:0]    wr_row,
  output logic [COL_BIT_LEN-1:0]    wr_col,
  output logic [CHAR_ID_LENGTH-1:0] wr_char,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam logic [ROW_BIT_LEN-1:0] LastRow = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LastCol = COL_BIT_LEN'(COL_NUMBER - 1);

  typedef enum logic [1:0] {StClearAll, StIdle, StClearRow} state_e;

  state_e                    state_q;
  logic [ROW_BIT_LEN-1:0]    cur_row_q, clr_row_q;
  logic [COL_BIT_LEN-1:0]    cur_col_q, clr_col_q;
  logic                      clr_last_q;
  logic                      wr_en_q;
  logic [ROW_BIT_LEN-1:0]    wr_row_q;
  logic [COL_BIT_LEN-1:0]    wr_col_q;
  logic [CHAR_ID_LENGTH-1:0] wr_char_q;
  logic                      printable;

  function automatic logic [ROW_BIT_LEN-1:0] next_row(input logic [ROW_BIT_LEN-1:0] r);
    return (r == LastRow) ? '0 : r + ROW_BIT_LEN'(1);
  endfunction

  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StClearAll;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      clr_row_q  <= '0;
      clr_col_q  <= '0;
      clr_last_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_char_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StClearAll: begin
          // clr_last_q marks that the final cell went out on the previous edge.
          if (clr_last_q) begin
            state_q    <= StIdle;
            clr_last_q <= 1'b0;
          end else begin
            wr_en_q    <= 1'b1;
            wr_row_q   <= clr_row_q;
            wr_col_q   <= clr_col_q;
            wr_char_q  <= BLANK_CHAR;
            clr_last_q <= (clr_row_q == LastRow) && (clr_col_q == LastCol);
            if (clr_col_q == LastCol) begin
              clr_col_q <= '0;
              clr_row_q <= next_row(clr_row_q);
            end else begin
              clr_col_q <= clr_col_q + COL_BIT_LEN'(1);
            end
          end
        end
        StClearRow: begin
          if (clr_last_q) begin
            state_q    <= StIdle;
            clr_last_q <= 1'b0;
          end else begin
            wr_en_q    <= 1'b1;
            wr_row_q   <= cur_row_q;
            wr_col_q   <= clr_col_q;
            wr_char_q  <= BLANK_CHAR;
            clr_last_q <= (clr_col_q == LastCol);
            clr_col_q  <= clr_col_q + COL_BIT_LEN'(1);
          end
        end
        StIdle: begin
          clr_row_q  <= '0;
          clr_col_q  <= '0;
          clr_last_q <= 1'b0;
          if (in_valid) begin
            if (printable) begin
              wr_en_q   <= 1'b1;
              wr_row_q  <= cur_row_q;
              wr_col_q  <= cur_col_q;
              wr_char_q <= CHAR_ID_LENGTH'(in_data);
              if (cur_col_q == LastCol) begin
                cur_col_q <= '0;
                cur_row_q <= next_row(cur_row_q);
                state_q   <= StClearRow;
              end else begin
                cur_col_q <= cur_col_q + COL_BIT_LEN'(1);
              end
            end else begin
              unique case (in_data)
                8'h0A: begin
                  cur_col_q <= '0;
                  cur_row_q <= next_row(cur_row_q);
                  state_q   <= StClearRow;
                end
                8'h0D: cur_col_q <= '0;
                8'h08: begin
                  // Backspace never crosses back into the previous line.
                  if (cur_col_q != '0) begin
                    cur_col_q <= cur_col_q - COL_BIT_LEN'(1);
                    wr_en_q   <= 1'b1;
                    wr_row_q  <= cur_row_q;
                    wr_col_q  <= cur_col_q - COL_BIT_LEN'(1);
                    wr_char_q <= BLANK_CHAR;
                  end
                end
                8'h0C: begin
                  cur_row_q <= '0;
                  cur_col_q <= '0;
                  state_q   <= StClearAll;
                end
                default: ;
              endcase
            end
          end
        end
        default: state_q <= StClearAll;
      endcase
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = ~in_ready;
  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_col     = wr_col_q;
  assign wr_char    = wr_char_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;

endmodule

// File: doc/text_cursor_writer.md
Name: text_cursor_writer

Overview:
- Upstream feeder for the character plane: converts a byte stream (ASCII, e.g. from a UART receiver) into single-cell write commands (row, col, char id, write strobe) for the text buffer, which the pixel encoder scans out.
- Maintains the text cursor and interprets control codes: CR, LF, BS, FF.
- Clears the screen after reset, and clears each new line on entry, so stale text never shows.
- Output is registered; at most one cell write per clk.

Parameters:
- ROW_NUMBER, 15, text lines on screen
- COL_NUMBER, 40, characters per line
- CHAR_ID_LENGTH, 8, width of character id
- ROW_BIT_LEN, 4, width of row index, ceil(log2(ROW_NUMBER))
- COL_BIT_LEN, 6, width of col index, ceil(log2(COL_NUMBER))
- BLANK_CHAR, 8'h20, char id written when clearing or erasing

Ports:
- clk  in  1  system clock (only clock)
- reset  in  1  synchronous, active-high reset
- in_data  in  8  incoming byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte this cycle
- wr_en  out  1  cell write strobe, one cycle per cell
- wr_row  out  ROW_BIT_LEN  row of cell write
- wr_col  out  COL_BIT_LEN  column of cell write
- wr_char  out  CHAR_ID_LENGTH  char id to write
- cursor_row  out  ROW_BIT_LEN  current cursor row
- cursor_col  out  COL_BIT_LEN  current cursor column
- busy  out  1  high in any clear state (equals !in_ready)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high. All outputs are registered except in_ready and busy, which decode the state register.
- States: CLEAR_ALL, IDLE, CLEAR_ROW. in_ready = (state==IDLE).
- Byte accept: on a clk edge with in_valid & in_ready. in_data is ignored when in_ready=0; the byte is not lost, the source holds it.

Reset:
- Values at reset: state=CLEAR_ALL, cursor=(0,0), wr_en=0, wr_row=0, wr_col=0, wr_char=0.
- Reset mid-operation aborts any clear or write and restarts CLEAR_ALL.

CLEAR_ALL:
- Writes BLANK_CHAR to every cell, column fastest: (0,0),(0,1)..(0,39),(1,0)..(14,39).
- First strobe is on the first edge after reset deasserts; one cell per cycle, ROW_NUMBER*COL_NUMBER = 600 strobes.
- The edge after the (14,39) strobe sets state=IDLE and wr_en=0. Cursor ends at (0,0).

IDLE accept: outputs update on the accepting edge. wr_en=0 on any edge with no write.
- Printable (0x20..0x7E):
  - Strobe (cursor_row, cursor_col, in_data).
  - If col<COL_NUMBER-1: col+1, stay IDLE. Throughput is 1 byte/cycle.
  - Else (line wrap): col=0, row=row+1, with row ROW_NUMBER-1 wrapping to 0; state=CLEAR_ROW.
- 0x0A LF: no strobe; col=0, row advances with wrap as above; state=CLEAR_ROW.
- 0x0D CR: no strobe; col=0; row unchanged.
- 0x08 BS:
  - col>0: col-1 and strobe (row, col-1, BLANK_CHAR).
  - col=0: no-op, no strobe, never moves to the previous row.
- 0x0C FF: no strobe; cursor=(0,0); state=CLEAR_ALL, with identical 600-cycle sequence.
- Any other byte: consumed, no strobe, cursor unchanged.

CLEAR_ROW:
- Strobes (cursor_row, c, BLANK_CHAR) for c=0..COL_NUMBER-1 on consecutive edges.
- The first strobe is on the edge after the entering edge.
- The edge after the c=COL_NUMBER-1 strobe sets state=IDLE and wr_en=0. Cursor is unchanged during the clear.
- A wrap char costs 1 + COL_NUMBER + 1 cycles before the next accept.

Widths and visibility:
- Row/col arithmetic uses explicit compare-and-wrap, never relying on power-of-2 overflow.
- cursor_row/cursor_col always show the post-update cursor, visible the cycle after the accepting edge.

Test Plan:
- Reset 1 cycle then release: exactly 600 wr_en strobes, all wr_char=0x20; first (0,0), last (14,39). in_ready=0 throughout, then 1; cursor=(0,0).
- After init, stream "HI" back-to-back: in_ready stays 1; strobes (0,0,0x48), (0,1,0x49) on consecutive edges; cursor=(0,2).
- 40 printables from (0,0): last strobe (0,39,char), then 40 strobes (1,0..39,0x20). in_ready low exactly 41 cycles; cursor=(1,0).
- Cursor (14,5), send 0x0A: no char strobe; clear strobes on row 0; cursor=(0,0).
- Cursor (3,0), send 0x08: no strobe, cursor (3,0). Then 'A', 0x08: strobes (3,0,0x41), then (3,0,0x20); cursor=(3,0). Then 0x0D, 0x07: no strobes, cursor=(3,0).
- Mid-CLEAR_ROW (after 10 strobes), assert reset 1 cycle: wr_en=0 during reset; full 600-cell clear restarts at (0,0); cursor=(0,0). Also 0x0C from (7,12): 600-strobe clear, cursor=(0,0).
